// File: rtl/stack_engine.sv
// stack_engine: operand-stack datapath of the single-cycle stack processor.
// Applies the decoder's StackUpdateMode / StackWriteSrc fields to a
// register-file stack and presents the top two entries (tos, nos).
// Optional feature macro: STACK_GUARD_EN. When it is defined, illegal
// updates are blocked and the overflow/underflow flags and err_pulse are
// raised. When it is undefined, the next count is truncated and applied
// unconditionally, and the error outputs are tied low.
module stack_engine #(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 16,
  parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          StackUpdateMode,
  input  logic [1:0]          StackWriteSrc,
  input  logic [REG_BITS-1:0] alu_result,
  input  logic [REG_BITS-1:0] dmem_rdata,
  input  logic [REG_BITS-1:0] pc_temp,
  input  logic                clr_err,
  output logic [REG_BITS-1:0] tos,
  output logic [REG_BITS-1:0] nos,
  output logic [CNT_BITS-1:0] count,
  output logic                err_pulse,
  output logic                overflow,
  output logic                underflow
);

  localparam int IDX_BITS = $clog2(DEPTH);

  logic [REG_BITS-1:0]        mem [DEPTH];
  logic signed [CNT_BITS:0]   delta;
  logic signed [CNT_BITS:0]   count_nxt;
  logic [REG_BITS-1:0]        wr_data;
  logic                       wr_en;
  logic [IDX_BITS-1:0]        wr_idx;
  logic [IDX_BITS-1:0]        tos_idx;
  logic [IDX_BITS-1:0]        nos_idx;
  logic                       legal;

  // Decode the count adjustment; one bit wider than the counter so that
  // negative results and DEPTH+1 are both representable.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    delta = '0;
    case (StackUpdateMode)
      2'b00:   delta = '0;
      2'b01:   delta = (CNT_BITS+1)'(1);
      2'b10:   delta = (CNT_BITS+1)'(-2);
      default: delta = (CNT_BITS+1)'(-1);
    endcase
  end

  // Select the write data from the requested source.
  always_comb begin
    wr_data = '0;
    case (StackWriteSrc)
      2'b01:   wr_data = alu_result;
      2'b10:   wr_data = dmem_rdata;
      2'b11:   wr_data = pc_temp;
      default: wr_data = '0;
    endcase
  end

  assign wr_en     = (StackWriteSrc != 2'b00);
  assign count_nxt = $signed({1'b0, count}) + delta;
  // The new top lands at count_nxt-1; low bits give the modulo-DEPTH slot.
  assign wr_idx    = IDX_BITS'(count_nxt - 1);
  assign tos_idx   = IDX_BITS'(count - CNT_BITS'(1));
  assign nos_idx   = IDX_BITS'(count - CNT_BITS'(2));

  // Combinational read of the top two entries; empty slots read as zero.
  assign tos = (count == '0)           ? '0 : mem[tos_idx];
  assign nos = (count < CNT_BITS'(2))  ? '0 : mem[nos_idx];

`ifdef STACK_GUARD_EN
  logic under_c;
  logic over_c;

  // Writing with a resulting count of zero would target slot -1.
  assign under_c = (count_nxt < 0) || (wr_en && (count_nxt == 0));
  assign over_c  = (count_nxt > DEPTH);
  assign legal   = !under_c && !over_c;

  // Sticky error flags and the one-cycle rejection pulse; a set on the
  // same edge as clr_err takes priority because it is assigned last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      err_pulse <= en && !legal;
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (en && over_c)  overflow  <= 1'b1;
      if (en && under_c) underflow <= 1'b1;
    end
  end
`else
  logic unused_clr_err;

  assign legal          = 1'b1;
  assign err_pulse      = 1'b0;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
  assign unused_clr_err = clr_err;
`endif

  // Count and storage update on each retiring instruction that is legal.
  // NOTE: the register array is reset because a reset must leave every entry at zero; it is small enough to be flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en && legal) begin
      // NOTE: sequential state uses non-blocking assignment so all flops sample the pre-edge values.
      count <= CNT_BITS'(count_nxt);
      if (wr_en) mem[wr_idx] <= wr_data;
    end
  end

endmodule
